// File: rtl/mac_sequencer_pkg.sv
// rtl/mac_sequencer_pkg.sv - shared types and constants for the MAC sequencer
package mac_sequencer_pkg;

  localparam int DEF_REG_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH     = 4;
  localparam int DEF_LEN_WIDTH      = 8;

  localparam logic FUNCT_LOAD = 1'b1;
  localparam logic FUNCT_MAC  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIAS = 2'd1,
    ST_MAC  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_addr_gen.sv
// rtl/mac_addr_gen.sv - wrapping operand pointers and term down-counter
import mac_sequencer_pkg::*;

module mac_addr_gen #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_a_i,
  input  logic [ADDR_WIDTH-1:0] base_b_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] pa_o,
  output logic [ADDR_WIDTH-1:0] pb_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] pa_q, pa_d;
  logic [ADDR_WIDTH-1:0] pb_q, pb_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    pa_d  = pa_q;
    pb_d  = pb_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pa_d  = base_a_i;
      pb_d  = base_b_i;
      cnt_d = len_i;
    end else if (step_i) begin
      // Pointers roll over naturally at the address width.
      pa_d  = pa_q + ADDR_WIDTH'(1);
      pb_d  = pb_q + ADDR_WIDTH'(1);
      cnt_d = cnt_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pa_q  <= '0;
      pb_q  <= '0;
      cnt_q <= '0;
    end else begin
      pa_q  <= pa_d;
      pb_q  <= pb_d;
      cnt_q <= cnt_d;
    end
  end

  assign pa_o   = pa_q;
  assign pb_o   = pb_q;
  assign last_o = (cnt_q == LEN_WIDTH'(1));

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - sequences one bias-seeded dot product on the shared ALU
import mac_sequencer_pkg::*;

module mac_sequencer #(
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_a_i,
  input  logic [ADDR_WIDTH-1:0] base_b_i,
  input  logic [ADDR_WIDTH-1:0] bias_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [ADDR_WIDTH-1:0] rs2_addr_o,
  output logic                  funct_o,
  output logic                  mac_en_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] bias_q, bias_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                  len_zero_q, len_zero_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] pa, pb;
  logic                  last;

  // The data path width never changes control behaviour; it only has to be sane.
  a_data_width: assert property (@(posedge clk_i) REG_DATA_WIDTH >= 2);

  assign accept = (state_q == ST_IDLE) && start_i;

  mac_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .step_i   (state_q == ST_MAC),
    .base_a_i (base_a_i),
    .base_b_i (base_b_i),
    .len_i    (len_i),
    .pa_o     (pa),
    .pb_o     (pb),
    .last_o   (last)
  );

  always_comb begin
    state_d    = state_q;
    bias_d     = bias_q;
    dst_d      = dst_q;
    len_zero_d = len_zero_q;
    done_d     = 1'b0;
    busy_o     = 1'b0;
    rs1_addr_o = '0;
    rs2_addr_o = '0;
    funct_o    = FUNCT_MAC;
    mac_en_o   = 1'b0;
    wr_en_o    = 1'b0;
    wr_addr_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bias_d     = bias_addr_i;
          dst_d      = dst_addr_i;
          len_zero_d = (len_i == '0);
          state_d    = ST_BIAS;
        end
      end
      ST_BIAS: begin
        busy_o     = 1'b1;
        rs1_addr_o = bias_q;
        funct_o    = FUNCT_LOAD;
        mac_en_o   = 1'b1;
        // With no terms the loaded bias is already the result on rd.
        if (len_zero_q) begin
          wr_en_o   = 1'b1;
          wr_addr_o = dst_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_MAC;
        end
      end
      ST_MAC: begin
        busy_o     = 1'b1;
        rs1_addr_o = pa;
        rs2_addr_o = pb;
        funct_o    = FUNCT_MAC;
        mac_en_o   = 1'b1;
        if (last) begin
          wr_en_o   = 1'b1;
          wr_addr_o = dst_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bias_q     <= '0;
      dst_q      <= '0;
      len_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bias_q     <= bias_d;
      dst_q      <= dst_d;
      len_zero_q <= len_zero_d;
      done_q     <= done_d;
    end
  end

  assign done_o = done_q;

endmodule
